// File: rtl/regfile_sb.sv
// 32x32 register file with a 2-bit-per-register pending-write scoreboard and sticky overflow/underflow flags.
// Optional same-cycle write-back bypass: define REGFILE_BYPASS_EN.
module regfile_sb (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [4:0]  WriteBackReg,
    input  logic [31:0] WriteBackData,
    input  logic [4:0]  Read_register1,
    input  logic [4:0]  Read_register2,
    output logic [31:0] Read_data1,
    output logic [31:0] Read_data2,
    input  logic        Issue_valid,
    input  logic [4:0]  Issue_reg,
    output logic        Busy1,
    output logic        Busy2,
    output logic        Sb_overflow,
    output logic        Sb_underflow
);

    logic [31:0] regs     [1:31];
    logic [1:0]  cnt      [1:31];
    logic [1:0]  cnt_next [1:31];

    logic        wb_en;
    logic        iss_en;
    logic        ovf_set;
    logic        udf_set;

    logic [31:0] stored1;
    logic [31:0] stored2;
    logic [1:0]  cnt1;
    logic [1:0]  cnt2;

    assign wb_en  = RegWrite && (WriteBackReg != '0);
    assign iss_en = Issue_valid && (Issue_reg != '0);

    // An issue and a write-back to the same register cancel, so neither saturation check applies.
    always_comb begin
        ovf_set = 1'b0;
        udf_set = 1'b0;
        for (int unsigned i = 1; i < 32; i++) begin
            logic inc;
            logic dec;
            inc = iss_en && (Issue_reg == 5'(i));
            dec = wb_en && (WriteBackReg == 5'(i));
            cnt_next[i] = cnt[i];
            if (inc && !dec) begin
                if (cnt[i] == 2'd3) begin
                    ovf_set = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + 2'd1;
                end
            end else if (dec && !inc) begin
                if (cnt[i] == 2'd0) begin
                    udf_set = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 1; i < 32; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            Sb_overflow  <= 1'b0;
            Sb_underflow <= 1'b0;
        end else begin
            for (int unsigned i = 1; i < 32; i++) begin
                if (wb_en && (WriteBackReg == 5'(i))) begin
                    regs[i] <= WriteBackData;
                end
                cnt[i] <= cnt_next[i];
            end
            if (ovf_set) begin
                Sb_overflow <= 1'b1;
            end
            if (udf_set) begin
                Sb_underflow <= 1'b1;
            end
        end
    end

    always_comb begin
        stored1 = '0;
        stored2 = '0;
        cnt1    = '0;
        cnt2    = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            if (Read_register1 == 5'(i)) begin
                stored1 = regs[i];
                cnt1    = cnt[i];
            end
            if (Read_register2 == 5'(i)) begin
                stored2 = regs[i];
                cnt2    = cnt[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic hit1;
    logic hit2;

    // Reset gates the bypass so outputs read zero for the whole reset window.
    assign hit1 = !reset && wb_en && (WriteBackReg == Read_register1);
    assign hit2 = !reset && wb_en && (WriteBackReg == Read_register2);

    assign Read_data1 = hit1 ? WriteBackData : stored1;
    assign Read_data2 = hit2 ? WriteBackData : stored2;
    assign Busy1      = (cnt1 != 2'd0) && !(hit1 && (cnt1 == 2'd1));
    assign Busy2      = (cnt2 != 2'd0) && !(hit2 && (cnt2 == 2'd1));
`else
    assign Read_data1 = stored1;
    assign Read_data2 = stored2;
    assign Busy1      = (cnt1 != 2'd0);
    assign Busy2      = (cnt2 != 2'd0);
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: driver predicts each cycle's outputs from an array model, monitor compares at negedge.
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteBackReg;
    logic [31:0] WriteBackData;
    logic [4:0]  Read_register1;
    logic [4:0]  Read_register2;
    logic [31:0] Read_data1;
    logic [31:0] Read_data2;
    logic        Issue_valid;
    logic [4:0]  Issue_reg;
    logic        Busy1;
    logic        Busy2;
    logic        Sb_overflow;
    logic        Sb_underflow;

    regfile_sb dut (
        .clk(clk), .reset(reset),
        .RegWrite(RegWrite), .WriteBackReg(WriteBackReg), .WriteBackData(WriteBackData),
        .Read_register1(Read_register1), .Read_register2(Read_register2),
        .Read_data1(Read_data1), .Read_data2(Read_data2),
        .Issue_valid(Issue_valid), .Issue_reg(Issue_reg),
        .Busy1(Busy1), .Busy2(Busy2),
        .Sb_overflow(Sb_overflow), .Sb_underflow(Sb_underflow)
    );

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic        ovf;
        logic        udf;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_reg[32];
    int          m_cnt[32];
    bit          m_ovf;
    bit          m_udf;
    int          tests;
    int          fails;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = '0;
            m_cnt[i] = 0;
        end
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    function automatic logic [31:0] pred_data(input logic [4:0] r);
        if (reset || r == 0) return '0;
        if (BYPASS && RegWrite && WriteBackReg == r) return WriteBackData;
        return m_reg[r];
    endfunction

    function automatic logic pred_busy(input logic [4:0] r);
        if (reset || r == 0 || m_cnt[r] == 0) return 1'b0;
        if (BYPASS && RegWrite && WriteBackReg == r && m_cnt[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    // Applies one clock edge worth of issue/write-back rules to the model.
    task automatic model_edge(input bit iv, input int ir, input bit rw, input int wr,
                              input logic [31:0] wd);
        bit inc;
        bit dec;
        inc = iv && ir != 0;
        dec = rw && wr != 0;
        if (dec) m_reg[wr] = wd;
        if (!(inc && dec && ir == wr)) begin
            if (inc) begin
                if (m_cnt[ir] == 3) m_ovf = 1'b1;
                else m_cnt[ir] = m_cnt[ir] + 1;
            end
            if (dec) begin
                if (m_cnt[wr] == 0) m_udf = 1'b1;
                else m_cnt[wr] = m_cnt[wr] - 1;
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit iv, input logic [4:0] ir,
                         input bit rw, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        reset          = rst;
        Issue_valid    = iv;
        Issue_reg      = ir;
        RegWrite       = rw;
        WriteBackReg   = wr;
        WriteBackData  = wd;
        Read_register1 = r1;
        Read_register2 = r2;
        if (rst) model_clear();
        e.rd1 = pred_data(r1);
        e.rd2 = pred_data(r2);
        e.b1  = pred_busy(r1);
        e.b2  = pred_busy(r2);
        e.ovf = rst ? 1'b0 : m_ovf;
        e.udf = rst ? 1'b0 : m_udf;
        sbq.push_back(e);
        @(posedge clk);
        if (!rst) model_edge(iv, int'(ir), rw, int'(wr), wd);
        #2;
    endtask

    task automatic rst_cycle();
        cycle(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, '0, 5'd1, 5'd2);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("Read_data1", Read_data1, e.rd1);
                chk("Read_data2", Read_data2, e.rd2);
                chk("Busy1", 32'(Busy1), 32'(e.b1));
                chk("Busy2", 32'(Busy2), 32'(e.b2));
                chk("Sb_overflow", 32'(Sb_overflow), 32'(e.ovf));
                chk("Sb_underflow", 32'(Sb_underflow), 32'(e.udf));
            end
        end
    end

    initial begin : driver
        tests = 0;
        fails = 0;
        reset = 1'b1;
        RegWrite = 1'b0; WriteBackReg = '0; WriteBackData = '0;
        Issue_valid = 1'b0; Issue_reg = '0;
        Read_register1 = '0; Read_register2 = '0;
        model_clear();
        @(posedge clk);
        #2;
        rst_cycle();
        rst_cycle();

        // write/read R5, write to R0 ignored
        cycle(0, 0, 0, 1, 5, 32'h12345678, 5, 0);
        cycle(0, 0, 0, 1, 0, 32'hFFFFFFFF, 5, 0);
        cycle(0, 0, 0, 0, 0, '0, 0, 5);

        // two issues to R7, then two write-backs
        rst_cycle();
        cycle(0, 1, 7, 0, 0, '0, 7, 0);
        cycle(0, 1, 7, 0, 0, '0, 7, 0);
        cycle(0, 0, 0, 1, 7, 32'h00000777, 7, 0);
        cycle(0, 0, 0, 0, 0, '0, 7, 0);
        cycle(0, 0, 0, 1, 7, 32'h00007777, 7, 7);
        cycle(0, 0, 0, 0, 0, '0, 7, 7);

        // same-edge issue and write-back to R3 at count 1
        rst_cycle();
        cycle(0, 1, 3, 0, 0, '0, 3, 0);
        cycle(0, 1, 3, 1, 3, 32'h33, 3, 0);
        cycle(0, 0, 0, 0, 0, '0, 3, 3);

        // overflow on R9, then underflow on R10
        rst_cycle();
        for (int i = 0; i < 4; i++) cycle(0, 1, 9, 0, 0, '0, 9, 0);
        cycle(0, 0, 0, 1, 10, 32'h10, 9, 10);
        cycle(0, 0, 0, 0, 0, '0, 9, 10);

        // same-cycle write and read of R4 at count 1
        rst_cycle();
        cycle(0, 1, 4, 0, 0, '0, 4, 0);
        cycle(0, 0, 0, 1, 4, 32'hA5A5A5A5, 4, 4);
        cycle(0, 0, 0, 0, 0, '0, 4, 4);

        // reset between edges while R2 is busy holding 0x55
        rst_cycle();
        cycle(0, 1, 2, 0, 0, '0, 2, 0);
        cycle(0, 1, 2, 0, 0, '0, 2, 0);
        cycle(0, 0, 0, 1, 2, 32'h55, 2, 2);
        cycle(0, 0, 0, 0, 0, '0, 2, 2);
        cycle(1, 0, 0, 0, 0, '0, 2, 2);
        cycle(0, 0, 0, 0, 0, '0, 2, 2);

        // randomized traffic on a narrow register range to force collisions
        rst_cycle();
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom % 150) == 0,
                  1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
